// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line/frame counters plus a DELAY-stage pipeline
// that aligns sync, active and strobe outputs with a pipelined pixel renderer.
module vga_timing_gen #(
    parameter int BIT        = 10,
    parameter int FRAME_BITS = 8,
    parameter int HRES       = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int VRES       = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_POL      = 0,
    parameter int V_POL      = 0,
    parameter int DELAY      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_ce,
    output logic [BIT-1:0]        x_pos,
    output logic [BIT-1:0]        y_pos,
    output logic [FRAME_BITS-1:0] frame_cnt,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  active,
    output logic                  line_start,
    output logic                  frame_start
);

    localparam int H_TOTAL = HRES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = VRES + V_FP + V_SYNC + V_BP;

    // Boundaries computed as int, then narrowed so every compare is BIT-wide unsigned.
    localparam logic [BIT-1:0] H_LAST     = BIT'(H_TOTAL - 1);
    localparam logic [BIT-1:0] V_LAST     = BIT'(V_TOTAL - 1);
    localparam logic [BIT-1:0] H_ACT_END  = BIT'(HRES);
    localparam logic [BIT-1:0] V_ACT_END  = BIT'(VRES);
    localparam logic [BIT-1:0] HS_FIRST   = BIT'(HRES + H_FP);
    localparam logic [BIT-1:0] HS_LAST    = BIT'(HRES + H_FP + H_SYNC - 1);
    localparam logic [BIT-1:0] VS_FIRST   = BIT'(VRES + V_FP);
    localparam logic [BIT-1:0] VS_LAST    = BIT'(VRES + V_FP + V_SYNC - 1);
    localparam logic           H_ASSERTED = (H_POL != 0);
    localparam logic           V_ASSERTED = (V_POL != 0);

    logic       hs;
    logic       vs;
    logic       act;
    logic       ls;
    logic       fs;
    logic [4:0] decoded;
    logic [4:0] pipe [DELAY];
    logic [4:0] tail;

    // On the last pixel of a frame, x, y and frame_cnt all roll over on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos     <= '0;
            y_pos     <= '0;
            frame_cnt <= '0;
        end else if (pix_ce) begin
            if (x_pos == H_LAST) begin
                x_pos <= '0;
                if (y_pos == V_LAST) begin
                    y_pos     <= '0;
                    frame_cnt <= frame_cnt + FRAME_BITS'(1);
                end else begin
                    y_pos <= y_pos + BIT'(1);
                end
            end else begin
                x_pos <= x_pos + BIT'(1);
            end
        end
    end

    assign hs  = (x_pos >= HS_FIRST) && (x_pos <= HS_LAST);
    assign vs  = (y_pos >= VS_FIRST) && (y_pos <= VS_LAST);
    assign act = (x_pos < H_ACT_END) && (y_pos < V_ACT_END);
    assign ls  = (x_pos == '0);
    assign fs  = (x_pos == '0) && (y_pos == '0);
    assign decoded = {hs, vs, act, ls, fs};

    // Pipeline holds the raw (active-high) decode; polarity is applied only at the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe[i] <= '0;
            end
        end else if (pix_ce) begin
            pipe[0] <= decoded;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail        = pipe[DELAY-1];
    assign h_sync      = tail[4] ? H_ASSERTED : ~H_ASSERTED;
    assign v_sync      = tail[3] ? V_ASSERTED : ~V_ASSERTED;
    assign active      = tail[2];
    assign line_start  = tail[1];
    assign frame_start = tail[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full default timing, a short-frame variant,
// and a tiny inverted-polarity DELAY=1 variant used for wrap and lag checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic pix_ce;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    always #5 clk = ~clk;

    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;
    logic       d_hs, d_vs, d_act, d_ls, d_fs;

    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       a_hs, a_vs, a_act, a_ls, a_fs;

    logic [3:0] b_x, b_y;
    logic [2:0] b_fc;
    logic       b_hs, b_vs, b_act, b_ls, b_fs;

    logic [48:0] all_out;
    assign all_out = {d_x, d_y, d_fc, d_hs, d_vs, d_act, d_ls, d_fs,
                      b_x, b_y, b_fc, b_hs, b_vs, b_act, b_ls, b_fs};

    vga_timing_gen dut_def (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .x_pos(d_x), .y_pos(d_y), .frame_cnt(d_fc),
        .h_sync(d_hs), .v_sync(d_vs), .active(d_act),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // Default horizontal timing with an 8-line frame so vertical events are reachable quickly.
    vga_timing_gen #(
        .VRES(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .x_pos(a_x), .y_pos(a_y), .frame_cnt(a_fc),
        .h_sync(a_hs), .v_sync(a_vs), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .BIT(4), .FRAME_BITS(3),
        .HRES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .VRES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1), .DELAY(1)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_ce(pix_ce),
        .x_pos(b_x), .y_pos(b_y), .frame_cnt(b_fc),
        .h_sync(b_hs), .v_sync(b_vs), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        pix_ce = 1'b0;
        step();
        checks++;
        if ({d_x, d_y, d_fc} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL reset_def_counters: got %h expected 0", {d_x, d_y, d_fc});
        end
        checks++;
        if ({d_hs, d_vs, d_act, d_ls, d_fs} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL reset_def_outputs: got %b expected 11000", {d_hs, d_vs, d_act, d_ls, d_fs});
        end
        checks++;
        if ({b_x, b_y, b_fc} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL reset_b_counters: got %h expected 0", {b_x, b_y, b_fc});
        end
        checks++;
        if ({b_hs, b_vs, b_act, b_ls, b_fs} !== 5'b00000) begin
            failures++;
            $display("[TB] FAIL reset_b_outputs: got %b expected 00000", {b_hs, b_vs, b_act, b_ls, b_fs});
        end
        reset  = 1'b0;
        pix_ce = 1'b1;
        cycle  = 0;
    endtask

    task automatic test_startup();
        checks++;
        if ({d_hs, d_vs, d_act} !== 3'b110) begin
            failures++;
            $display("[TB] FAIL start_c0_def: got %b expected 110", {d_hs, d_vs, d_act});
        end
        checks++;
        if ({b_act, b_fs} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL start_c0_b: got %b expected 00", {b_act, b_fs});
        end
        step();
        checks++;
        if ({d_hs, d_vs, d_act, d_ls} !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL start_c1_def: got %b expected 1100", {d_hs, d_vs, d_act, d_ls});
        end
        checks++;
        if ({b_x, b_hs, b_vs, b_act, b_ls, b_fs} !== {4'd1, 5'b00111}) begin
            failures++;
            $display("[TB] FAIL start_c1_b_lag: got %h expected %h",
                     {b_x, b_hs, b_vs, b_act, b_ls, b_fs}, {4'd1, 5'b00111});
        end
        step();
        checks++;
        if ({d_x, d_act, d_ls, d_fs} !== {10'd2, 3'b111}) begin
            failures++;
            $display("[TB] FAIL start_c2_def: got %h expected %h", {d_x, d_act, d_ls, d_fs}, {10'd2, 3'b111});
        end
        step();
        checks++;
        if ({d_x, d_act, d_ls, d_fs} !== {10'd3, 3'b100}) begin
            failures++;
            $display("[TB] FAIL start_c3_def: got %h expected %h", {d_x, d_act, d_ls, d_fs}, {10'd3, 3'b100});
        end
    endtask

    task automatic test_hsync();
        int  low_cnt     = 0;
        int  first_low_x = -1;
        int  act_fall_x  = -1;
        logic prev_act   = 1'b1;
        for (int i = 0; i < 800; i++) begin
            step();
            if (!d_hs) begin
                low_cnt++;
                if (first_low_x < 0) first_low_x = int'(d_x);
            end
            if (prev_act && !d_act && act_fall_x < 0) act_fall_x = int'(d_x);
            prev_act = d_act;
            if (cycle == 800) begin
                checks++;
                if ({d_x, d_y} !== {10'd0, 10'd1}) begin
                    failures++;
                    $display("[TB] FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", d_x, d_y);
                end
            end
            if (cycle == 802) begin
                checks++;
                if ({d_ls, d_fs, d_act} !== 3'b101) begin
                    failures++;
                    $display("[TB] FAIL line1_start: got %b expected 101", {d_ls, d_fs, d_act});
                end
            end
        end
        checks++;
        if (first_low_x != 658) begin
            failures++;
            $display("[TB] FAIL hsync_first_x: got %0d expected 658", first_low_x);
        end
        checks++;
        if (low_cnt != 96) begin
            failures++;
            $display("[TB] FAIL hsync_width: got %0d expected 96", low_cnt);
        end
        checks++;
        if (act_fall_x != 642) begin
            failures++;
            $display("[TB] FAIL active_fall_x: got %0d expected 642", act_fall_x);
        end
    endtask

    task automatic test_vsync_frame();
        int low_cnt     = 0;
        int first_low_x = -1;
        int first_low_y = -1;
        while (cycle < 6400) begin
            step();
            if (!a_vs) begin
                low_cnt++;
                if (first_low_x < 0) begin
                    first_low_x = int'(a_x);
                    first_low_y = int'(a_y);
                end
            end
        end
        checks++;
        if (first_low_y != 5 || first_low_x != 2) begin
            failures++;
            $display("[TB] FAIL vsync_fall_pos: got y=%0d x=%0d expected y=5 x=2", first_low_y, first_low_x);
        end
        checks++;
        if (low_cnt != 1600) begin
            failures++;
            $display("[TB] FAIL vsync_width: got %0d expected 1600", low_cnt);
        end
        checks++;
        if ({a_x, a_y, a_fc} !== {10'd0, 10'd0, 8'd1}) begin
            failures++;
            $display("[TB] FAIL a_frame_wrap: got x=%0d y=%0d f=%0d expected 0 0 1", a_x, a_y, a_fc);
        end
        checks++;
        if ({d_x, d_y, d_fc} !== {10'd0, 10'd8, 8'd0}) begin
            failures++;
            $display("[TB] FAIL def_at_6400: got x=%0d y=%0d f=%0d expected 0 8 0", d_x, d_y, d_fc);
        end
        checks++;
        if ({b_x, b_y, b_fc} !== {4'd0, 4'd0, 3'd2}) begin
            failures++;
            $display("[TB] FAIL b_at_6400: got x=%0d y=%0d f=%0d expected 0 0 2", b_x, b_y, b_fc);
        end
        step();
        step();
        checks++;
        if ({a_fs, a_ls, a_act, d_fs, d_ls} !== 5'b11101) begin
            failures++;
            $display("[TB] FAIL frame_start_6402: got %b expected 11101", {a_fs, a_ls, a_act, d_fs, d_ls});
        end
    endtask

    task automatic test_ce_half();
        int          changes   = 0;
        int          ls_clocks = 0;
        logic [48:0] snap;
        reset  = 1'b1;
        pix_ce = 1'b1;
        step();
        reset = 1'b0;
        cycle = 0;
        for (int k = 1; k <= 1600; k++) begin
            pix_ce = (k % 2) == 1;
            snap   = all_out;
            step();
            if (!pix_ce && all_out !== snap) changes++;
            if (d_ls) ls_clocks++;
        end
        pix_ce = 1'b1;
        checks++;
        if (changes != 0) begin
            failures++;
            $display("[TB] FAIL ce_hold: got %0d changes expected 0", changes);
        end
        checks++;
        if (ls_clocks != 2) begin
            failures++;
            $display("[TB] FAIL ce_ls_width: got %0d expected 2", ls_clocks);
        end
        checks++;
        if ({d_x, d_y} !== {10'd0, 10'd1}) begin
            failures++;
            $display("[TB] FAIL ce_line_time: got x=%0d y=%0d expected 0 1", d_x, d_y);
        end
    endtask

    task automatic test_midframe_reset();
        reset  = 1'b1;
        pix_ce = 1'b1;
        step();
        reset = 1'b0;
        cycle = 0;
        while (cycle < 33900) step();
        checks++;
        if ({a_x, a_y, a_fc, a_act} !== {10'd300, 10'd2, 8'd5, 1'b1}) begin
            failures++;
            $display("[TB] FAIL pre_reset_a: got x=%0d y=%0d f=%0d act=%b expected 300 2 5 1",
                     a_x, a_y, a_fc, a_act);
        end
        checks++;
        if ({d_x, d_y, d_fc} !== {10'd300, 10'd42, 8'd0}) begin
            failures++;
            $display("[TB] FAIL pre_reset_def: got x=%0d y=%0d f=%0d expected 300 42 0", d_x, d_y, d_fc);
        end
        checks++;
        if ({b_x, b_y, b_fc, b_hs, b_vs} !== {4'd12, 4'd6, 3'd0, 2'b11}) begin
            failures++;
            $display("[TB] FAIL pre_reset_b: got %h expected %h",
                     {b_x, b_y, b_fc, b_hs, b_vs}, {4'd12, 4'd6, 3'd0, 2'b11});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cycle = 0;
        checks++;
        if ({a_x, a_y, a_fc} !== 28'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset_a_cnt: got %h expected 0", {a_x, a_y, a_fc});
        end
        checks++;
        if ({a_hs, a_vs, a_act, a_ls, a_fs} !== 5'b11000) begin
            failures++;
            $display("[TB] FAIL mid_reset_a_out: got %b expected 11000", {a_hs, a_vs, a_act, a_ls, a_fs});
        end
        checks++;
        if ({b_x, b_y, b_fc, b_hs, b_vs, b_act, b_ls, b_fs} !== 16'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset_b: got %h expected 0",
                     {b_x, b_y, b_fc, b_hs, b_vs, b_act, b_ls, b_fs});
        end
    endtask

    task automatic test_b_frame_wrap();
        int hs_cnt     = 0;
        int first_hs_x = -1;
        while (cycle < 1024) begin
            step();
            if (cycle <= 16 && b_hs) begin
                hs_cnt++;
                if (first_hs_x < 0) first_hs_x = int'(b_x);
            end
            if (cycle == 128) begin
                checks++;
                if ({b_x, b_y, b_fc} !== {4'd0, 4'd0, 3'd1}) begin
                    failures++;
                    $display("[TB] FAIL b_frame1: got x=%0d y=%0d f=%0d expected 0 0 1", b_x, b_y, b_fc);
                end
            end
            if (cycle == 129) begin
                checks++;
                if ({b_x, b_fs, b_ls} !== {4'd1, 2'b11}) begin
                    failures++;
                    $display("[TB] FAIL b_frame1_start: got %h expected %h", {b_x, b_fs, b_ls}, {4'd1, 2'b11});
                end
            end
            if (cycle == 1023) begin
                checks++;
                if ({b_x, b_y, b_fc} !== {4'd15, 4'd7, 3'd7}) begin
                    failures++;
                    $display("[TB] FAIL b_last_pixel: got x=%0d y=%0d f=%0d expected 15 7 7", b_x, b_y, b_fc);
                end
            end
        end
        checks++;
        if ({b_x, b_y, b_fc} !== 11'd0) begin
            failures++;
            $display("[TB] FAIL b_frame_cnt_wrap: got x=%0d y=%0d f=%0d expected 0 0 0", b_x, b_y, b_fc);
        end
        checks++;
        if (first_hs_x != 11 || hs_cnt != 3) begin
            failures++;
            $display("[TB] FAIL b_hsync_inverted: got first_x=%0d width=%0d expected 11 3", first_hs_x, hs_cnt);
        end
    endtask

    initial begin
        reset  = 1'b1;
        pix_ce = 1'b0;
        test_reset();
        test_startup();
        test_hsync();
        test_vsync_frame();
        test_ce_half();
        test_midframe_reset();
        test_b_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
